command_arbiter: RTL and testbench
==================================

COMMAND_ARBITER -- requirements
Module: command_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the command channel.
REQ-002 Parameter CW, default 8: command word width in bits.
REQ-003 Parameter TIMEOUT, default 1000: maximum clk cycles spent waiting for ready_command before the command is aborted.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; rst=0 SHALL force reset state immediately, with release taking effect synchronously to clk.
REQ-006 req  input  NREQ  per-requester request level, bit i = requester i.
REQ-007 cmd_in  input  NREQ*CW  flattened command words; requester i occupies bits [i*CW +: CW].
REQ-008 ready_command  input  1  command engine completion strobe, sampled only in WAIT.
REQ-009 start  output  1  one-cycle pulse that launches the command engine.
REQ-010 command_1  output  CW  command word presented to the engine; held stable from ISSUE through WAIT.
REQ-011 grant  output  NREQ  one-hot owner of the channel; all zero when IDLE.
REQ-012 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-013 timeout_err  output  1  one-cycle pulse on abort due to TIMEOUT.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT and FINISH, encoded in 2 bits.
REQ-015 IDLE: if any req bit is 1, select the winner by round-robin starting at index ptr, latch grant and command_1 = cmd_in[winner], then go to ISSUE; otherwise remain in IDLE.
REQ-016 Round-robin: search ptr, ptr+1, ... modulo NREQ; the first asserted req bit wins.
REQ-017 ISSUE: start=1 for exactly one cycle; clear the wait counter to 0; go to WAIT.
REQ-018 WAIT: ready_command=1 -> FINISH. Otherwise increment the wait counter; when the counter reaches TIMEOUT-1 without ready_command, pulse timeout_err and return to IDLE without pulsing done.
REQ-019 ready_command=1 in the same cycle the counter reaches TIMEOUT-1 SHALL count as success; timeout_err stays 0.
REQ-020 FINISH: done[winner]=1 for one cycle; grant is cleared on exit; go to IDLE.
REQ-021 ptr SHALL be updated to (winner+1) mod NREQ on leaving FINISH and on timeout abort, giving every requester at most NREQ-1 waits.
REQ-022 Latency: request seen in IDLE at cycle n -> start at cycle n+1. ready_command at cycle m -> done at cycle m+1. Earliest next grant at cycle m+2.
REQ-023 ready_command asserted outside WAIT SHALL be ignored.
REQ-024 req deasserted after grant SHALL NOT abort the transaction; changes to cmd_in after latching SHALL NOT affect command_1.
REQ-025 At most one grant bit and at most one done bit SHALL be high in any cycle.
REQ-026 The wait counter SHALL be clog2(TIMEOUT) bits wide and SHALL saturate, never wrap.

Reset
REQ-027 In reset: state=IDLE, ptr=0, counter=0, start=0, command_1=0, grant=0, done=0, timeout_err=0.
REQ-028 Reset asserted in any state, including mid-WAIT, SHALL abort the transaction with no done or timeout_err pulse.
REQ-029 After reset release, the first arbitration SHALL start from requester 0.

Verification
REQ-030 Single request: req=0001, cmd_in[7:0]=8'hA5, ready_command 5 cycles after start -> start pulse one cycle after req, command_1=8'hA5, done=0001 one cycle after ready_command.
REQ-031 Contention: req=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-032 Timeout: TIMEOUT=16, ready_command never asserted -> timeout_err pulses 16 cycles after start, done stays 0, ptr advances.
REQ-033 Boundary: ready_command in the same cycle as counter=TIMEOUT-1 -> done pulses, timeout_err=0.
REQ-034 Reset mid-WAIT: rst=0 for 3 cycles during WAIT -> all outputs 0 immediately, and the next grant goes to requester 0.
REQ-035 Stray strobe: ready_command pulsed in IDLE with req=0 -> no start, done or grant activity.

Source files
------------

// File: rtl/command_arbiter.sv
// Round-robin arbiter that grants one requester at a time access to a shared
// command engine, issues its command word, and waits for completion or timeout.
module command_arbiter #(
  parameter int NREQ    = 4,
  parameter int CW      = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] cmd_in,
  input  logic               ready_command,
  output logic               start,
  output logic [CW-1:0]      command_1,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               timeout_err,
  output logic [1:0]         state_dbg
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, win, sel, ptr_after;
  logic [PW:0]     cand;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   cmd_sel;
  logic            found;
  logic            wait_expired;

  // Engine handshake: start is a single-cycle launch strobe while command_1 is
  // stable; ready_command is a completion strobe honoured only in S_WAIT.

  // Round-robin search beginning at ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        sel   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == PW'(i)) cmd_sel = cmd_in[i*CW +: CW];
    end
  end

  assign ptr_after    = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
  assign wait_expired = (state == S_WAIT) && !ready_command && (cnt == CNT_LAST);

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    done        = '0;
    timeout_err = 1'b0;
    case (state)
      S_IDLE:   if (found) state_nxt = S_ISSUE;
      S_ISSUE: begin
        start     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (ready_command) begin
          state_nxt = S_FINISH;
        end else if (wait_expired) begin
          timeout_err = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_FINISH: begin
        done      = grant;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      win       <= '0;
      cnt       <= '0;
      grant     <= '0;
      command_1 <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant     <= NREQ'(1) << sel;
            win       <= sel;
            command_1 <= cmd_sel;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          // Counter stops at its last value rather than wrapping.
          if (!ready_command && cnt != CNT_LAST) cnt <= cnt + CNTW'(1);
          if (wait_expired) begin
            grant <= '0;
            ptr   <= ptr_after;
          end
        end
        S_FINISH: begin
          grant <= '0;
          ptr   <= ptr_after;
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_command_arbiter.sv
// Directed self-checking bench for command_arbiter: latency, round-robin order,
// timeout, success-at-boundary, reset mid-transaction and stray strobes.
module tb_command_arbiter;
  localparam int NREQ    = 4;
  localparam int CW      = 8;
  localparam int TIMEOUT = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*CW-1:0] cmd_in = '0;
  logic               ready_command = 1'b0;
  logic               start;
  logic [CW-1:0]      command_1;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               timeout_err;
  logic [1:0]         state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  command_arbiter #(.NREQ(NREQ), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd_in(cmd_in),
    .ready_command(ready_command), .start(start), .command_1(command_1),
    .grant(grant), .done(done), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    step();
    while (!start && n < 20) begin
      step();
      n++;
    end
    check({tag, "_start_seen"}, 32'(start), 32'd1);
  endtask

  initial begin
    logic [NREQ-1:0] exp_g;
    logic [CW-1:0]   exp_cmd;

    // Reset values
    repeat (2) step();
    check("rst_start", 32'(start), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_cmd", 32'(command_1), 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b1;
    step();
    check("rel_state", 32'(state_dbg), 32'(ST_IDLE));

    // Single request, ready 5 cycles after start
    req = 4'b0001;
    cmd_in = 32'h4433_22A5;
    step();
    check("single_start", 32'(start), 1);
    check("single_grant", 32'(grant), 32'h1);
    check("single_cmd", 32'(command_1), 32'hA5);
    check("single_state", 32'(state_dbg), 32'(ST_ISSUE));
    req = '0;
    cmd_in = 32'hFFFF_FF5A;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("single_wait_start", 32'(start), 0);
      check("single_wait_done", 32'(done), 0);
      check("single_cmd_hold", 32'(command_1), 32'hA5);
    end
    step();
    ready_command = 1'b1;
    step();
    ready_command = 1'b0;
    check("single_done", 32'(done), 32'h1);
    check("single_no_to", 32'(timeout_err), 0);
    step();
    check("single_done_clr", 32'(done), 0);
    check("single_grant_clr", 32'(grant), 0);
    check("single_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Contention from a fresh reset: order 0,1,2,3,0,1,2,3
    rst = 1'b0;
    step();
    rst = 1'b1;
    cmd_in = 32'hD3C2_B1A0;
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp_g   = 4'(1 << (t % 4));
      exp_cmd = 8'hA0 + 8'(8'h11 * (t % 4));
      wait_start("rr");
      check("rr_grant", 32'(grant), 32'(exp_g));
      check("rr_cmd", 32'(command_1), 32'(exp_cmd));
      if (t == 0) begin
        ready_command = 1'b1;
        step();
        ready_command = 1'b0;
        check("issue_ready_ignored", 32'(state_dbg), 32'(ST_WAIT));
        check("issue_ready_no_done", 32'(done), 0);
      end
      step();
      ready_command = 1'b1;
      step();
      ready_command = 1'b0;
      check("rr_done", 32'(done), 32'(exp_g));
    end
    req = '0;

    // Timeout: requester 2, no ready
    req = 4'b0100;
    wait_start("to");
    check("to_grant", 32'(grant), 32'h4);
    req = '0;
    for (int k = 1; k <= 15; k++) begin
      step();
      check("to_early", 32'(timeout_err), 0);
    end
    step();
    check("to_pulse", 32'(timeout_err), 1);
    check("to_no_done", 32'(done), 0);
    step();
    check("to_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("to_grant_clr", 32'(grant), 0);
    check("to_pulse_clr", 32'(timeout_err), 0);

    // Pointer advanced to 3; ready on the last count is a success
    req = 4'b1101;
    wait_start("bnd");
    check("bnd_grant", 32'(grant), 32'h8);
    req = '0;
    repeat (16) step();
    ready_command = 1'b1;
    #1;
    check("bnd_no_to", 32'(timeout_err), 0);
    check("bnd_state", 32'(state_dbg), 32'(ST_WAIT));
    step();
    ready_command = 1'b0;
    check("bnd_done", 32'(done), 32'h8);
    check("bnd_no_to2", 32'(timeout_err), 0);
    step();

    // Move ptr to 3, then reset in the middle of a WAIT
    req = 4'b0100;
    wait_start("pre");
    req = '0;
    step();
    ready_command = 1'b1;
    step();
    ready_command = 1'b0;
    check("pre_done", 32'(done), 32'h4);
    req = 4'b0010;
    wait_start("mid");
    check("mid_grant", 32'(grant), 32'h2);
    req = '0;
    repeat (2) step();
    check("mid_state", 32'(state_dbg), 32'(ST_WAIT));
    rst = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_start", 32'(start), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_cmd", 32'(command_1), 0);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_rst_hold_done", 32'(done), 0);
      check("mid_rst_hold_to", 32'(timeout_err), 0);
    end
    rst = 1'b1;
    req = 4'b1111;
    wait_start("post");
    check("post_grant", 32'(grant), 32'h1);
    req = '0;
    step();
    ready_command = 1'b1;
    step();
    ready_command = 1'b0;
    check("post_done", 32'(done), 32'h1);
    step();

    // Stray ready strobes in IDLE
    ready_command = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("stray_start", 32'(start), 0);
      check("stray_grant", 32'(grant), 0);
      check("stray_done", 32'(done), 0);
      check("stray_state", 32'(state_dbg), 32'(ST_IDLE));
    end
    ready_command = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
